// File: rtl/fifo_bit_reader.sv
// fifo_bit_reader: pops bytes from the encoder FIFO and hands out 0..MAXB-bit groups through a residual bit buffer
module fifo_bit_reader #(
  parameter int DWIDTH = 8,
  parameter int MAXB = 15,
  parameter int NBW = 4,
  parameter int FW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty_i,
  output logic              fifo_re_o,
  input  logic [DWIDTH-1:0] fifo_data_i,
  input  logic              req_i,
  input  logic [NBW-1:0]    nbits_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [MAXB-1:0]   data_o,
  output logic              starve_o,
  output logic [FW-1:0]     fill_o,
  input  logic              flush_i
);
  localparam int BW = MAXB + DWIDTH - 1;
  localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, WAIT = 2'd2;
  logic [1:0]      state;
  logic [BW-1:0]   bit_buf;
  logic [FW-1:0]   fill;
  logic [NBW-1:0]  nb, nb_clamp;
  logic [MAXB-1:0] mask;
  logic            short_w;
  assign nb_clamp = 32'(nbits_i) > MAXB ? NBW'(MAXB) : nbits_i;
  assign mask = ~({MAXB{1'b1}} << nb);
  assign short_w = state == EVAL && fill < FW'(nb);
  assign fifo_re_o = short_w && !fifo_empty_i;
  assign starve_o = short_w && fifo_empty_i;
  assign ready_o = state == IDLE;
  assign fill_o = fill;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      bit_buf <= '0;
      fill <= '0;
      nb <= '0;
      done_o <= 1'b0;
      data_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      bit_buf <= '0;
      fill <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == IDLE && req_i) begin
        nb <= nb_clamp;
        state <= EVAL;
      end else if (state == EVAL && !short_w) begin
        data_o <= bit_buf[MAXB-1:0] & mask;
        bit_buf <= bit_buf >> nb;
        fill <= fill - FW'(nb);
        done_o <= 1'b1;
        state <= IDLE;
      end else if (fifo_re_o) begin
        state <= WAIT;
      end else if (state == WAIT) begin
        bit_buf <= bit_buf | (BW'(fifo_data_i) << fill);
        fill <= fill + FW'(DWIDTH);
        state <= EVAL;
      end
    end
endmodule

// File: tb/tb_fifo_bit_reader.sv
// tb_fifo_bit_reader: table of request vectors plus hand sequences for starvation, flush and reset
module tb_fifo_bit_reader;
  logic        clk = 0, reset = 1, fifo_empty_i = 1, req_i = 0, flush_i = 0;
  logic        fifo_re_o, ready_o, done_o, starve_o;
  logic [7:0]  fifo_data_i = 0;
  logic [3:0]  nbits_i = 0;
  logic [14:0] data_o;
  logic [4:0]  fill_o;
  logic        push_v = 0, bad_pop = 0;
  logic [7:0]  push_b = 0;
  int          pops = 0, nvec = 0, nerr = 0, cyc = 0, pops0 = 0;
  logic [7:0]  fq[$];
  int          exp_q[$];
  typedef struct {int nb; int data; int fill; int pops; int lat;} vec_t;
  vec_t vt[7];

  fifo_bit_reader dut (
    .clk(clk), .reset(reset), .fifo_empty_i(fifo_empty_i), .fifo_re_o(fifo_re_o),
    .fifo_data_i(fifo_data_i), .req_i(req_i), .nbits_i(nbits_i), .ready_o(ready_o),
    .done_o(done_o), .data_o(data_o), .starve_o(starve_o), .fill_o(fill_o), .flush_i(flush_i)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after the pop, writes land on the edge
  always @(posedge clk) begin
    if (fifo_re_o && fq.size() > 0) begin
      fifo_data_i <= fq.pop_front();
      pops <= pops + 1;
    end else if (fifo_re_o) bad_pop <= 1'b1;
    if (push_v) fq.push_back(push_b);
    fifo_empty_i <= fq.size() == 0;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_v = 1;
    push_b = b;
    @(negedge clk);
    push_v = 0;
  endtask

  task automatic start_req(input int nb);
    req_i = 1;
    nbits_i = 4'(nb);
    @(posedge clk);
    @(negedge clk);
    req_i = 0;
    cyc = 1;
  endtask

  task automatic wait_done(input string name, input int exp_fill, input int exp_lat);
    int k;
    for (k = 0; k < 40 && !done_o; k++) begin
      @(negedge clk);
      cyc++;
    end
    if (!done_o) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_data"}, int'(data_o), exp_q.pop_front());
      chk({name, "_fill"}, int'(fill_o), exp_fill);
      chk({name, "_ready"}, int'(ready_o), 1);
      if (exp_lat >= 0) chk({name, "_lat"}, cyc, exp_lat);
    end
  endtask

  initial begin
    vt[0] = '{4, 'h5, 4, 1, 4};
    vt[1] = '{8, 'hCA, 4, 2, 4};
    vt[2] = '{4, 'h3, 0, 2, 2};
    vt[3] = '{3, 'h2, 5, 3, 4};
    vt[4] = '{15, 'h4682, 6, 5, 6};
    vt[5] = '{0, 'h0, 6, 5, 2};
    vt[6] = '{6, 'h15, 0, 5, 2};
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready_o), 1);
    chk("rst_done", int'(done_o), 0);
    chk("rst_re", int'(fifo_re_o), 0);
    chk("rst_starve", int'(starve_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_fill", int'(fill_o), 0);
    reset = 0;
    @(negedge clk);
    foreach (vt[i]) ;
    push_byte(8'hA5);
    push_byte(8'h3C);
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vt[i].data);
      start_req(vt[i].nb);
      wait_done($sformatf("vec%0d", i), vt[i].fill, vt[i].lat);
      chk($sformatf("vec%0d_pops", i), pops, vt[i].pops);
    end
    // starvation: request with an empty FIFO, then a late byte
    start_req(3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("starve_hi", int'(starve_o), 1);
      chk("starve_re", int'(fifo_re_o), 0);
    end
    push_v = 1;
    push_b = 8'h06;
    @(negedge clk);
    push_v = 0;
    chk("starve_lo", int'(starve_o), 0);
    chk("starve_pop", int'(fifo_re_o), 1);
    exp_q.push_back('h6);
    wait_done("starve", 5, -1);
    // flush while the popped byte is in flight
    push_byte(8'h77);
    push_byte(8'h88);
    pops0 = pops;
    start_req(8);
    chk("fl_pop", int'(fifo_re_o), 1);
    @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    chk("fl_fill", int'(fill_o), 0);
    chk("fl_ready", int'(ready_o), 1);
    chk("fl_done", int'(done_o), 0);
    chk("fl_lost", pops - pops0, 1);
    @(negedge clk);
    chk("fl_done2", int'(done_o), 0);
    exp_q.push_back('h88);
    start_req(8);
    wait_done("after_flush", 0, 4);
    // reset while starving in EVAL with 4 bits buffered
    push_byte(8'h9A);
    exp_q.push_back('hA);
    start_req(4);
    wait_done("pre_rst", 4, 4);
    @(negedge clk);
    start_req(8);
    chk("mid_fill", int'(fill_o), 4);
    chk("mid_starve", int'(starve_o), 1);
    reset = 1;
    #1;
    chk("mr_ready", int'(ready_o), 1);
    chk("mr_starve", int'(starve_o), 0);
    chk("mr_re", int'(fifo_re_o), 0);
    chk("mr_done", int'(done_o), 0);
    chk("mr_data", int'(data_o), 0);
    chk("mr_fill", int'(fill_o), 0);
    @(negedge clk);
    reset = 0;
    push_byte(8'hC3);
    exp_q.push_back('hC3);
    start_req(8);
    wait_done("post_rst", 0, 4);
    chk("no_empty_pop", int'(bad_pop), 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fifo_bit_reader.md
# fifo_bit_reader

Read-side companion of the constellation encoder's byte FIFO: pops bytes from the FIFO and hands out variable-width bit groups (0..MAXB bits, one group per tone) to the constellation mapper. It keeps a bit buffer of residual bits so that byte boundaries and tone bit-loading are decoupled. The block sits between the FIFO read port and the tone-order/constellation mapping stage.

## Interface

Parameters:
- DWIDTH, 8, FIFO word width in bits.
- MAXB, 15, maximum bits per request.
- NBW, 4, width of nbits_i; must hold MAXB.
- FW, 5, width of the fill counter; must hold MAXB+DWIDTH-1.

Ports:
- clk  in  1  clock; all state changes on the posedge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_re_o  out  1  FIFO read enable; one pop per high cycle.
- fifo_data_i  in  DWIDTH  FIFO read data; valid the cycle after fifo_re_o.
- req_i  in  1  single-cycle request strobe; accepted only while ready_o=1.
- nbits_i  in  NBW  bits requested; sampled with req_i.
- ready_o  out  1  block idle; a new req_i may be issued.
- done_o  out  1  one-cycle pulse; data_o is valid.
- data_o  out  MAXB  extracted bits, right-aligned, zero-filled above nbits; held until the next done_o.
- starve_o  out  1  request pending, buffer short, FIFO empty.
- fill_o  out  FW  number of valid bits in the buffer.
- flush_i  in  1  synchronous discard of the buffer and any pending request.

## Operation

- Bit buffer: MAXB+DWIDTH-1 bits. Valid bits are buf[fill-1:0]. The oldest bit is at bit 0.
- Byte load: buf |= fifo_data_i << fill, then fill += DWIDTH. The byte's LSB is consumed first.
- Extraction: data_o <= buf & ((1<<nb)-1), buf <= buf >> nb, fill -= nb.
- nb is nbits_i latched at acceptance. Values above MAXB are clamped to MAXB.
- nb=0 completes normally with data_o=0; fill is unchanged.
- State machine:
  - IDLE:
    - ready_o=1.
    - req_i: latch nb, go to EVAL.
  - EVAL:
    - fill>=nb: extract, register done_o=1, go to IDLE.
    - else, fifo_empty_i=0: drive fifo_re_o=1 combinationally, go to WAIT.
    - else: stay in EVAL with starve_o=1.
  - WAIT:
    - Load fifo_data_i, go to EVAL.
- fifo_re_o is asserted only in EVAL with fill<nb and fifo_empty_i=0. The block never pops an empty FIFO and never issues two pops back to back.
- Buffer never overflows: a load happens only when fill<=nb-1<=MAXB-1.
- flush_i has priority over all state logic:
  - buf=0, fill=0, state=IDLE, done_o=0; data_o is held.
  - A byte in flight in WAIT is discarded; it has already been popped from the FIFO.
- req_i while ready_o=0 is ignored.
- req_i in the same cycle as flush_i is ignored.

## Timing

- Reset values:
  - State IDLE: ready_o=1.
  - done_o=0, fifo_re_o=0, starve_o=0.
  - data_o=0, fill_o=0, buf=0.
- Reset mid-operation: immediate return to the reset values. A FIFO pop already issued is lost.
- Latency, request to done_o, with req_i in cycle 0:
  - Enough bits buffered: done_o in cycle 2.
  - One byte needed: EVAL c1 (pop), WAIT c2, EVAL c3, done_o c4.
  - Two bytes needed: done_o c6.
  - Each starved cycle adds one cycle.
- done_o and ready_o are both high in the done cycle. A req_i in that cycle is accepted, giving back-to-back throughput of one group per 2 cycles when no fetch is needed.
- fill_o reflects the register value and updates on the edge ending EVAL or WAIT.
- starve_o is combinational from state, fill, nb and fifo_empty_i.
- It deasserts in the cycle the FIFO becomes non-empty; fifo_re_o rises in that same cycle.

## Test plan

- Basic stream:
  - Stimulus: reset, FIFO holds 0xA5, 0x3C; requests of 4, 8, 4 bits.
  - Response: data_o=0x5, 0xCA, 0x3; fill_o=4, 4, 0 after each request; exactly 2 pops.
- Two-byte fetch:
  - Stimulus: empty buffer, FIFO holds 0xFF, 0x01; request 15 at cycle 0.
  - Response: pops in c1 and c3; done_o in c6 with data_o=0x01FF; fill_o=1.
- Starvation:
  - Stimulus: FIFO empty, request 3 bits.
  - Response: starve_o=1 and fifo_re_o=0 while the FIFO stays empty.
  - Stimulus: write 0x06.
  - Response: pop on the first non-empty cycle; done_o with data_o=0x6; fill_o=5.
- Zero and clamp:
  - Stimulus: request 0 bits.
  - Response: done_o at c2, data_o=0, fill_o unchanged, no pop.
  - Stimulus: nbits_i=15 after a narrow group.
  - Response: correct 15-bit group; buffer never exceeds 22 bits.
- Flush:
  - Stimulus: flush_i during WAIT.
  - Response: fill_o=0; no done_o; ready_o=1 next cycle; the FIFO has lost exactly one byte.
  - Stimulus: next request of 8 bits.
  - Response: data_o equals the following FIFO byte.
- Reset mid-operation:
  - Stimulus: reset asserted in EVAL with fill_o=4.
  - Response: all outputs at reset values the same cycle; after release, normal requests succeed.
